mux_rr_sel: RTL and testbench

- Parametrised successor to the datapath 8:1 selector.
- Selects one of N channels of WIDTH-bit data and registers the result into a one-entry output stage with valid/ready handshakes on every channel and on the output.
- Two modes:
  - Fixed: the channel is chosen by F, as in the existing selector.
  - Round-robin: fair arbitration among requesting channels.
- Used wherever several producers share one datapath consumer, e.g. write-back sources or a memory port.

---
 rtl/mux_rr_sel_pkg.sv | 31 +++
 rtl/mux_rr_sel_if.sv | 39 +++
 rtl/mux_rr_sel_rr_pick.sv | 47 ++++
 rtl/mux_rr_sel.sv | 110 +++++++++++
 tb/tb_mux_rr_sel.sv | 306 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/mux_rr_sel_pkg.sv
// ----------------------------------------------------------------------------
// mux_rr_sel_pkg
// Shared constants for the N:1 registered channel selector: default data
// width and channel count, the mode encoding, and a clog2 helper for callers
// that derive the select width from the channel count.
// No ports (package).
// ----------------------------------------------------------------------------
package mux_rr_sel_pkg;

    localparam int DEFAULT_WIDTH = 32;
    localparam int DEFAULT_N     = 8;

    typedef enum logic {
        MODE_FIXED = 1'b0,
        MODE_RR    = 1'b1
    } mode_e;

    // Smallest result r with 2**r >= value (0 for value <= 1).
    function automatic int clog2(input int value);
        int result;
        int span;
        result = 0;
        span   = 1;
        while (span < value) begin
            span   = span * 2;
            result = result + 1;
        end
        return result;
    endfunction

endpackage

// File: rtl/mux_rr_sel_if.sv
// ----------------------------------------------------------------------------
// mux_rr_sel_if
// Channel-side and output-side handshake bundle of the selector.
//   in_valid  [N]        per-channel request
//   in_data   [N*WIDTH]  packed channel data, channel i at [i*WIDTH +: WIDTH]
//   in_ready  [N]        per-channel accept, at most one bit high
//   out_valid            output stage holds a word
//   out_data  [WIDTH]    registered selected word
//   out_ch    [SELW]     channel that supplied out_data
//   out_ready            consumer takes out_data
// Modports: master = producers/consumer side, slave = the selector.
// ----------------------------------------------------------------------------
interface mux_rr_sel_if
    import mux_rr_sel_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH,
    parameter int N     = DEFAULT_N,
    parameter int SELW  = clog2(N)
) ();

    logic [N-1:0]       in_valid;
    logic [N*WIDTH-1:0] in_data;
    logic [N-1:0]       in_ready;
    logic               out_valid;
    logic [WIDTH-1:0]   out_data;
    logic [SELW-1:0]    out_ch;
    logic               out_ready;

    modport master (
        output in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data, out_ch
    );

    modport slave (
        input  in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data, out_ch
    );

endinterface

// File: rtl/mux_rr_sel_rr_pick.sv
// ----------------------------------------------------------------------------
// mux_rr_sel_rr_pick
// Round-robin picker: returns the first requesting channel found when
// scanning ptr, ptr+1, ..., N-1, 0, ..., ptr-1.
//   req   [N]     request vector
//   ptr   [SELW]  scan start (always < N)
//   idx   [SELW]  chosen channel (0 when nothing requests)
//   found         at least one channel requests
// ----------------------------------------------------------------------------
module mux_rr_sel_rr_pick
    import mux_rr_sel_pkg::*;
#(
    parameter int N    = DEFAULT_N,
    parameter int SELW = clog2(N)
) (
    input  logic [N-1:0]    req,
    input  logic [SELW-1:0] ptr,
    output logic [SELW-1:0] idx,
    output logic            found
);

    logic [N-1:0]    rot;
    logic [SELW-1:0] offset;
    logic [SELW:0]   sum;

    // Shifting the doubled vector right by ptr puts channel ptr at bit 0 and
    // wraps the lower channels in above it; the low N bits are the rotation.
    assign rot = N'({req, req} >> ptr);

    // NOTE: every always_comb output gets a value before any condition, so no
    // path through the block can leave it unassigned and infer a latch.
    always_comb begin
        offset = '0;
        // Downward scan: the last hit written is the lowest set bit.
        for (int i = N - 1; i >= 0; i--) begin
            if (rot[i]) begin
                offset = SELW'(i);
            end
        end
    end

    // Un-rotate: (ptr + offset) mod N, with both terms below N.
    assign sum   = {1'b0, ptr} + {1'b0, offset};
    assign idx   = (sum >= (SELW + 1)'(N)) ? SELW'(sum - (SELW + 1)'(N)) : sum[SELW-1:0];
    assign found = |req;

endmodule

// File: rtl/mux_rr_sel.sv
// ----------------------------------------------------------------------------
// mux_rr_sel
// N:1 channel selector with a one-entry registered output stage.
// Fixed mode takes the channel named by F; round-robin mode arbitrates
// fairly among requesting channels, starting after the last served one.
//   clk   rising-edge clock
//   rst   synchronous active-high reset
//   En    accept enable (0 blocks new accepts, held word still drains)
//   mode  0 = fixed select via F, 1 = round-robin
//   F     channel index used in fixed mode
//   bus   handshake bundle (slave view), see mux_rr_sel_if
// ----------------------------------------------------------------------------
module mux_rr_sel
    import mux_rr_sel_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH,
    parameter int N     = DEFAULT_N,
    parameter int SELW  = clog2(N)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            En,
    input  logic            mode,
    input  logic [SELW-1:0] F,
    mux_rr_sel_if.slave     bus
);

    localparam int SPAN = 1 << SELW;

    logic [SPAN-1:0]  valid_pad;
    logic             fixed_gv;
    logic [SELW-1:0]  rr_g;
    logic             rr_gv;
    logic [SELW-1:0]  g;
    logic             gv;
    logic             load;
    logic             xfer;
    logic [N-1:0]     ready_c;
    logic [WIDTH-1:0] sel_data;
    logic [SELW-1:0]  next_ptr;

    logic             out_valid_q;
    logic [WIDTH-1:0] out_data_q;
    logic [SELW-1:0]  out_ch_q;
    logic [SELW-1:0]  ptr;

    // Padding to the full select range lets F index safely even when F >= N.
    assign valid_pad = SPAN'(bus.in_valid);
    assign fixed_gv  = ({1'b0, F} < (SELW + 1)'(N)) && valid_pad[F];

    mux_rr_sel_rr_pick #(
        .N    (N),
        .SELW (SELW)
    ) u_rr_pick (
        .req   (bus.in_valid),
        .ptr   (ptr),
        .idx   (rr_g),
        .found (rr_gv)
    );

    always_comb begin
        g  = F;
        gv = fixed_gv;
        if (mode_e'(mode) == MODE_RR) begin
            g  = rr_g;
            gv = rr_gv;
        end
    end

    assign load = !out_valid_q || bus.out_ready;

    // A word accepted during reset would be thrown away, so no channel is
    // told it was taken while rst is high.
    assign xfer = !rst && En && load && gv;

    always_comb begin
        ready_c = '0;
        if (xfer) begin
            ready_c[g] = 1'b1;
        end
    end

    assign sel_data = bus.in_data[g * WIDTH +: WIDTH];
    assign next_ptr = (g == SELW'(N - 1)) ? '0 : g + SELW'(1);

    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_ch_q    <= '0;
            ptr         <= '0;
        end else if (load) begin
            // Output slot is free or being drained: refill or go empty.
            out_valid_q <= xfer;
            if (xfer) begin
                out_data_q <= sel_data;
                out_ch_q   <= g;
                ptr        <= next_ptr;
            end
        end
    end

    assign bus.in_ready  = ready_c;
    assign bus.out_valid = out_valid_q;
    assign bus.out_data  = out_data_q;
    assign bus.out_ch    = out_ch_q;

endmodule

// File: tb/tb_mux_rr_sel.sv
// ----------------------------------------------------------------------------
// tb_mux_rr_sel
// Bench for mux_rr_sel: an 8-channel instance tracked every cycle against a
// behavioural model, plus a 5-channel instance exercising pointer wrap and an
// out-of-range fixed select with literal expectations.
// ----------------------------------------------------------------------------
module tb_mux_rr_sel;

    logic       clk;
    logic       rst;
    logic       en;
    logic       mode;
    logic [2:0] f;
    logic       en5;
    logic       mode5;
    logic [2:0] f5;

    int n_checks = 0;
    int n_errors = 0;

    mux_rr_sel_if #(.WIDTH(32), .N(8), .SELW(3)) bus8 ();
    mux_rr_sel_if #(.WIDTH(8),  .N(5), .SELW(3)) bus5 ();

    mux_rr_sel #(.WIDTH(32), .N(8), .SELW(3)) dut8 (
        .clk  (clk),
        .rst  (rst),
        .En   (en),
        .mode (mode),
        .F    (f),
        .bus  (bus8)
    );

    mux_rr_sel #(.WIDTH(8), .N(5), .SELW(3)) dut5 (
        .clk  (clk),
        .rst  (rst),
        .En   (en5),
        .mode (mode5),
        .F    (f5),
        .bus  (bus5)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // ---------------- behavioural model of the 8-channel instance ----------
    logic        m_valid = 1'b0;
    logic [31:0] m_data  = '0;
    int          m_ch    = 0;
    int          m_ptr   = 0;

    // Channel that would be granted now, or -1 when none.
    function automatic int model_grant(input logic md, input int fsel,
                                       input logic [7:0] v, input int p);
        if (md == 1'b0) begin
            if (fsel < 8 && v[fsel]) return fsel;
            return -1;
        end
        for (int k = 0; k < 8; k++) begin
            if (v[(p + k) % 8]) return (p + k) % 8;
        end
        return -1;
    endfunction

    function automatic logic [31:0] pick_word(input logic [255:0] d, input int ch);
        return d[ch * 32 +: 32];
    endfunction

    function automatic logic [7:0] model_ready();
        int gr;
        gr = model_grant(mode, int'(f), bus8.in_valid, m_ptr);
        if (!rst && en && (!m_valid || bus8.out_ready) && gr >= 0) return 8'(1) << gr;
        return 8'h00;
    endfunction

    always @(posedge clk) begin
        if (rst) begin
            m_valid <= 1'b0;
            m_data  <= '0;
            m_ch    <= 0;
            m_ptr   <= 0;
        end else if (!m_valid || bus8.out_ready) begin
            if (en && model_grant(mode, int'(f), bus8.in_valid, m_ptr) >= 0) begin
                m_valid <= 1'b1;
                m_data  <= pick_word(bus8.in_data, model_grant(mode, int'(f), bus8.in_valid, m_ptr));
                m_ch    <= model_grant(mode, int'(f), bus8.in_valid, m_ptr);
                m_ptr   <= (model_grant(mode, int'(f), bus8.in_valid, m_ptr) + 1) % 8;
            end else begin
                m_valid <= 1'b0;
            end
        end
    end

    // Compare process: DUT against model on every falling edge.
    always @(negedge clk) begin
        check("model in_ready",  64'(bus8.in_ready),  64'(model_ready()));
        check("model out_valid", 64'(bus8.out_valid), 64'(m_valid));
        check("model out_data",  64'(bus8.out_data),  64'(m_data));
        check("model out_ch",    64'(bus8.out_ch),    64'(m_ch));
    end

    // ---------------- stimulus helpers ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic at_neg();
        @(negedge clk);
    endtask

    task automatic load_pattern8();
        for (int i = 0; i < 8; i++) bus8.in_data[i * 32 +: 32] = 32'hA0 + 32'(i);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    int rr_exp [6] = '{1, 4, 7, 1, 4, 7};

    initial begin
        rst  = 1'b1;
        en   = 1'b1;
        mode = 1'b1;
        f    = 3'd0;
        bus8.in_valid  = 8'hFF;
        bus8.out_ready = 1'b1;
        load_pattern8();
        en5   = 1'b1;
        mode5 = 1'b1;
        f5    = 3'd0;
        bus5.in_valid  = 5'b0;
        bus5.out_ready = 1'b1;
        for (int i = 0; i < 5; i++) bus5.in_data[i * 8 +: 8] = 8'h50 + 8'(i);

        // Reset held two cycles with every channel requesting.
        repeat (2) begin
            tick();
            at_neg();
            check("reset out_valid", 64'(bus8.out_valid), 64'(0));
            check("reset out_data",  64'(bus8.out_data),  64'(0));
            check("reset out_ch",    64'(bus8.out_ch),    64'(0));
            check("reset in_ready",  64'(bus8.in_ready),  64'(0));
        end
        rst = 1'b0;
        #1;
        check("first rr grant", 64'(bus8.in_ready), 64'h01);
        tick();
        at_neg();
        check("first word ch",   64'(bus8.out_ch),   64'(0));
        check("first word data", 64'(bus8.out_data), 64'hA0);

        // Fixed select of channel 5.
        mode = 1'b0;
        f    = 3'd5;
        #1;
        check("fixed in_ready", 64'(bus8.in_ready), 64'h20);
        repeat (3) begin
            tick();
            at_neg();
            check("fixed out_data",  64'(bus8.out_data),  64'hA5);
            check("fixed out_ch",    64'(bus8.out_ch),    64'(5));
            check("fixed out_valid", 64'(bus8.out_valid), 64'(1));
        end
        bus8.in_valid = 8'hDF;
        #1;
        check("fixed idle in_ready", 64'(bus8.in_ready), 64'(0));
        tick();
        at_neg();
        check("fixed idle out_valid", 64'(bus8.out_valid), 64'(0));
        check("fixed idle data hold", 64'(bus8.out_data),  64'hA5);

        // Round-robin fairness from ptr=0.
        rst = 1'b1;
        tick();
        rst  = 1'b0;
        mode = 1'b1;
        bus8.in_valid = 8'b1001_0010;
        for (int k = 0; k < 6; k++) begin
            tick();
            at_neg();
            check("rr out_ch",    64'(bus8.out_ch),    64'(rr_exp[k]));
            check("rr out_valid", 64'(bus8.out_valid), 64'(1));
        end

        // Backpressure on word A3.
        mode = 1'b0;
        f    = 3'd3;
        bus8.in_valid = 8'hFF;
        tick();
        at_neg();
        check("bp load data", 64'(bus8.out_data), 64'hA3);
        bus8.out_ready = 1'b0;
        f = 3'd6;
        #1;
        check("bp in_ready", 64'(bus8.in_ready), 64'(0));
        repeat (3) begin
            tick();
            at_neg();
            check("bp hold data",  64'(bus8.out_data),  64'hA3);
            check("bp hold valid", 64'(bus8.out_valid), 64'(1));
            check("bp in_ready",   64'(bus8.in_ready),  64'(0));
        end
        bus8.out_ready = 1'b1;
        #1;
        check("bp release in_ready", 64'(bus8.in_ready), 64'h40);
        tick();
        at_neg();
        check("bp replace data",  64'(bus8.out_data),  64'hA6);
        check("bp replace valid", 64'(bus8.out_valid), 64'(1));

        // Enable low drains the held word and blocks accepts.
        en = 1'b0;
        #1;
        check("en0 in_ready", 64'(bus8.in_ready), 64'(0));
        tick();
        at_neg();
        check("en0 out_valid", 64'(bus8.out_valid), 64'(0));
        en = 1'b1;
        #1;
        check("en1 in_ready", 64'(bus8.in_ready), 64'h40);
        tick();
        at_neg();
        check("en1 out_valid", 64'(bus8.out_valid), 64'(1));

        // Reset while a stalled word is held.
        bus8.out_ready = 1'b0;
        rst = 1'b1;
        #1;
        check("midrst in_ready", 64'(bus8.in_ready), 64'(0));
        tick();
        at_neg();
        check("midrst out_valid", 64'(bus8.out_valid), 64'(0));
        check("midrst out_data",  64'(bus8.out_data),  64'(0));
        rst  = 1'b0;
        mode = 1'b1;
        bus8.in_valid  = 8'hFF;
        bus8.out_ready = 1'b1;
        #1;
        check("midrst ptr zero", 64'(bus8.in_ready), 64'h01);

        // Randomised traffic, checked by the compare process.
        for (int c = 0; c < 600; c++) begin
            tick();
            if (c % 40 == 0) mode = 1'($urandom_range(0, 1));
            f  = 3'($urandom_range(0, 7));
            bus8.in_valid  = 8'($urandom);
            en             = ($urandom_range(0, 7) != 0);
            bus8.out_ready = ($urandom_range(0, 3) != 0);
            rst            = ($urandom_range(0, 63) == 0);
            for (int i = 0; i < 8; i++) bus8.in_data[i * 32 +: 32] = $urandom;
        end
        tick();
        rst = 1'b0;
        bus8.in_valid = 8'h00;
        tick();

        // Five-channel instance: pointer wrap and out-of-range fixed select.
        mode5 = 1'b1;
        bus5.in_valid = 5'b01000;
        #1;
        check("n5 grant 3", 64'(bus5.in_ready), 64'(5'b01000));
        tick();
        bus5.in_valid = 5'b00001;
        #1;
        check("n5 wrap grant 0", 64'(bus5.in_ready), 64'(5'b00001));
        tick();
        at_neg();
        check("n5 wrap out_ch",   64'(bus5.out_ch),   64'(0));
        check("n5 wrap out_data", 64'(bus5.out_data), 64'h50);
        bus5.in_valid = 5'b00011;
        #1;
        check("n5 ptr is 1", 64'(bus5.in_ready), 64'(5'b00010));
        tick();
        bus5.in_valid = 5'b10000;
        tick();
        bus5.in_valid = 5'b10001;
        #1;
        check("n5 ptr wraps to 0", 64'(bus5.in_ready), 64'(5'b00001));
        mode5 = 1'b0;
        f5    = 3'd7;
        bus5.in_valid = 5'b11111;
        #1;
        check("n5 F out of range", 64'(bus5.in_ready), 64'(0));
        f5 = 3'd4;
        #1;
        check("n5 F=4", 64'(bus5.in_ready), 64'(5'b10000));
        tick();
        at_neg();
        check("n5 F=4 out_ch", 64'(bus5.out_ch), 64'(4));

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
